// File: rtl/gate_vector_decoder_pkg.sv
// Package gvd_pkg: shared definitions for the gate-vector decoder.
//   GV_AND..GV_NOT : bit positions of each gate result inside the 7-bit vector
//   GV_W           : vector width
//   gvd_state_e    : code-health state {OK, SUSPECT, FAULT}
//   gv_encode(a,b) : the only legal vector for operands a,b
package gvd_pkg;

  localparam int GV_AND  = 0;
  localparam int GV_OR   = 1;
  localparam int GV_NAND = 2;
  localparam int GV_NOR  = 3;
  localparam int GV_XOR  = 4;
  localparam int GV_XNOR = 5;
  localparam int GV_NOT  = 6;
  localparam int GV_W    = 7;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    SUSPECT = 2'd1,
    FAULT   = 2'd2
  } gvd_state_e;

  function automatic logic [GV_W-1:0] gv_encode(input logic a, input logic b);
    logic [GV_W-1:0] z;
    z          = '0;
    z[GV_AND]  = a & b;
    z[GV_OR]   = a | b;
    z[GV_NAND] = ~(a & b);
    z[GV_NOR]  = ~(a | b);
    z[GV_XOR]  = a ^ b;
    z[GV_XNOR] = ~(a ^ b);
    z[GV_NOT]  = ~a;
    return z;
  endfunction

endpackage

// File: rtl/gate_vector_decoder_if.sv
// Interface gate_vector_decoder_if: the gate-vector link into the decoder and
// the decoded result link out of it.
//   z, in_valid, in_ready           : input side
//   a, b, code_err, out_valid,
//   out_ready                       : output side
//   syndrome (GVD_SYNDROME_EN only) : z ^ expected, aligned with a/b
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both 1. A source holds its payload stable while valid && !ready; ready may
// depend combinationally on the sink's own downstream ready.
// Modports: slave = decoder, master = the producer/consumer around it.
interface gate_vector_decoder_if;
  import gvd_pkg::*;

  logic [GV_W-1:0] z;
  logic            in_valid;
  logic            in_ready;
  logic            a;
  logic            b;
  logic            code_err;
  logic            out_valid;
  logic            out_ready;
`ifdef GVD_SYNDROME_EN
  logic [GV_W-1:0] syndrome;
`endif

  modport slave (
    input  z, in_valid, out_ready,
    output in_ready, a, b, code_err, out_valid
`ifdef GVD_SYNDROME_EN
    , output syndrome
`endif
  );

  modport master (
    output z, in_valid, out_ready,
    input  in_ready, a, b, code_err, out_valid
`ifdef GVD_SYNDROME_EN
    , input syndrome
`endif
  );

endinterface

// File: rtl/gate_vector_decoder_encode.sv
// Module gate_vector_encode: combinational operands -> legal gate vector.
//   a_i, b_i : operands
//   z_o      : legal 7-bit vector for (a_i, b_i)
module gate_vector_encode
  import gvd_pkg::*;
(
  input  logic            a_i,
  input  logic            b_i,
  output logic [GV_W-1:0] z_o
);

  assign z_o = gv_encode(a_i, b_i);

endmodule

// File: rtl/gate_vector_decoder.sv
// Module gate_vector_decoder: recovers operands a,b from a gate-result vector,
// flags vectors that are not the legal code for those operands, counts bad
// codes (saturating) and tracks a sticky FAULT state after FAULT_THRESH
// consecutive bad codes. One output register stage, full throughput.
// Optional feature macro: GVD_SYNDROME_EN adds gv.syndrome = z ^ expected.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   gv          : gate_vector_decoder_if.slave (input vector / decoded output)
//   clear       : synchronous clear of err_cnt, run length and state
//   err_cnt     : saturating bad-code count
//   fault       : state == FAULT
//   dbg_state   : current code-health state
module gate_vector_decoder
  import gvd_pkg::*;
#(
  parameter int ERR_W        = 8,
  parameter int FAULT_THRESH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gate_vector_decoder_if.slave  gv,
  input  logic                  clear,
  output logic [ERR_W-1:0]      err_cnt,
  output logic                  fault,
  output gvd_state_e            dbg_state
);

  logic            accept;
  logic            dec_a;
  logic            dec_b;
  logic [GV_W-1:0] expected;
  logic            bad;

  logic            a_q, b_q, code_err_q, out_valid_q;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_W-1:0] run_q, run_d, run_inc;
  gvd_state_e       state_q, state_d;

  // Operand recovery: a from the NOT lane, b from XOR = a ^ b.
  assign dec_a = ~gv.z[GV_NOT];
  assign dec_b = gv.z[GV_XOR] ^ dec_a;

  gate_vector_encode u_encode (
    .a_i (dec_a),
    .b_i (dec_b),
    .z_o (expected)
  );

  assign bad    = (gv.z != expected);
  assign accept = gv.in_valid && gv.in_ready;

  // Accept whenever the output register is empty or draining this cycle.
  assign gv.in_ready  = !out_valid_q || gv.out_ready;
  assign gv.a         = a_q;
  assign gv.b         = b_q;
  assign gv.code_err  = code_err_q;
  assign gv.out_valid = out_valid_q;
  assign err_cnt      = err_cnt_q;
  assign fault        = (state_q == FAULT);
  assign dbg_state    = state_q;

  // Output register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      code_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      a_q         <= dec_a;
      b_q         <= dec_b;
      code_err_q  <= bad;
      out_valid_q <= 1'b1;
    end else if (gv.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef GVD_SYNDROME_EN
  logic [GV_W-1:0] syndrome_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syndrome_q <= '0;
    end else if (accept) begin
      syndrome_q <= gv.z ^ expected;
    end
  end

  assign gv.syndrome = syndrome_q;
`endif

  // Bad-code counter: clear wins over a simultaneous bad accept.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clear) begin
      err_cnt_d = '0;
    end else if (accept && bad && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  // Code-health FSM, advances only on accepted vectors.
  assign run_inc = run_q + ERR_W'(1);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (clear) begin
      state_d = OK;
      run_d   = '0;
    end else if (accept) begin
      unique case (state_q)
        OK: begin
          if (bad) begin
            run_d   = ERR_W'(1);
            state_d = (FAULT_THRESH == 1) ? FAULT : SUSPECT;
          end
        end
        SUSPECT: begin
          if (bad) begin
            run_d = run_inc;
            if (run_inc == ERR_W'(FAULT_THRESH)) state_d = FAULT;
          end else begin
            run_d   = '0;
            state_d = OK;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = OK;
          run_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      run_q     <= '0;
      state_q   <= OK;
    end else begin
      err_cnt_q <= err_cnt_d;
      run_q     <= run_d;
      state_q   <= state_d;
    end
  end

endmodule

// File: tb/tb_gate_vector_decoder.sv
// Directed bench for gate_vector_decoder. Legal codes worked out by hand from
// the gate definitions (bit0 AND .. bit6 NOT a):
//   (a,b)=00 -> 7'h6C, 01 -> 7'h56, 10 -> 7'h16, 11 -> 7'h23
// 7'h00 decodes to a=1,b=1 and is illegal.
module tb_gate_vector_decoder;
  import gvd_pkg::*;

  logic clk;
  logic rst_n;
  logic clear, clear_s;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt_s;
  logic fault, fault_s;
  gvd_state_e st, st_s;

  int n_pass = 0;
  int n_chk  = 0;

  gate_vector_decoder_if gv ();
  gate_vector_decoder_if gvs ();

  gate_vector_decoder #(.ERR_W(8), .FAULT_THRESH(3)) dut (
    .clk(clk), .rst_n(rst_n), .gv(gv.slave), .clear(clear),
    .err_cnt(err_cnt), .fault(fault), .dbg_state(st)
  );

  gate_vector_decoder #(.ERR_W(2), .FAULT_THRESH(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .gv(gvs.slave), .clear(clear_s),
    .err_cnt(err_cnt_s), .fault(fault_s), .dbg_state(st_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: present one vector for one cycle (caller guarantees in_ready)
  task automatic send(input logic [6:0] zv);
    gv.z = zv;
    gv.in_valid = 1'b1;
    tick();
    gv.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear = 1'b0; clear_s = 1'b0;
    gv.z = 7'h00; gv.in_valid = 1'b0; gv.out_ready = 1'b1;
    gvs.z = 7'h00; gvs.in_valid = 1'b0; gvs.out_ready = 1'b1;
    tick(); tick();
    n_chk++; if (gv.out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", gv.out_valid); else n_pass++;
    n_chk++; if ({gv.a, gv.b, gv.code_err} !== 3'b000) $display("FAIL reset_a_b_err got %03b want 000", {gv.a, gv.b, gv.code_err}); else n_pass++;
    n_chk++; if (err_cnt !== 8'd0) $display("FAIL reset_err_cnt got %0d want 0", err_cnt); else n_pass++;
    n_chk++; if (fault !== 1'b0 || st !== OK) $display("FAIL reset_state got fault=%0b st=%0d want 0/OK", fault, st); else n_pass++;
    rst_n = 1'b1;
    tick();
    n_chk++; if (gv.in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", gv.in_ready); else n_pass++;
  endtask

  // back-to-back legal sweep, one output per cycle
  task automatic test_legal_sweep();
    logic [6:0] codes [4];
    codes = '{7'h6C, 7'h56, 7'h16, 7'h23};
    gv.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      gv.z = codes[i];
      gv.in_valid = 1'b1;
      tick();
      n_chk++;
      if ({gv.out_valid, gv.a, gv.b, gv.code_err} !== {1'b1, i[1], i[0], 1'b0})
        $display("FAIL sweep_%0d got v,a,b,err=%04b want %0b%0b%0b%0b", i,
                 {gv.out_valid, gv.a, gv.b, gv.code_err}, 1'b1, i[1], i[0], 1'b0);
      else n_pass++;
      n_chk++; if (gv.in_ready !== 1'b1) $display("FAIL sweep_in_ready_%0d got %0b want 1", i, gv.in_ready); else n_pass++;
    end
    gv.in_valid = 1'b0;
    tick();
    n_chk++; if (gv.out_valid !== 1'b0) $display("FAIL sweep_drain got %0b want 0", gv.out_valid); else n_pass++;
    n_chk++; if (err_cnt !== 8'd0) $display("FAIL sweep_err_cnt got %0d want 0", err_cnt); else n_pass++;
  endtask

  task automatic test_backpressure();
    gv.out_ready = 1'b0;
    send(7'h56);
    gv.z = 7'h16;
    gv.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if ({gv.in_ready, gv.out_valid, gv.a, gv.b} !== 4'b0101)
        $display("FAIL bp_hold_%0d got rdy,v,a,b=%04b want 0101", i, {gv.in_ready, gv.out_valid, gv.a, gv.b});
      else n_pass++;
      tick();
    end
    gv.out_ready = 1'b1;
    #1;
    n_chk++; if (gv.in_ready !== 1'b1) $display("FAIL bp_release_ready got %0b want 1", gv.in_ready); else n_pass++;
    tick();
    gv.in_valid = 1'b0;
    n_chk++;
    if ({gv.out_valid, gv.a, gv.b, gv.code_err} !== 4'b1100)
      $display("FAIL bp_next got v,a,b,err=%04b want 1100", {gv.out_valid, gv.a, gv.b, gv.code_err});
    else n_pass++;
    tick();
  endtask

  task automatic test_bad_code();
    gv.out_ready = 1'b1;
    send(7'h00);
    n_chk++;
    if ({gv.a, gv.b, gv.code_err} !== 3'b111) $display("FAIL bad_out got a,b,err=%03b want 111", {gv.a, gv.b, gv.code_err}); else n_pass++;
    n_chk++; if (err_cnt !== 8'd1) $display("FAIL bad_err_cnt got %0d want 1", err_cnt); else n_pass++;
    n_chk++; if (st !== SUSPECT) $display("FAIL bad_state got %0d want %0d", st, SUSPECT); else n_pass++;
    send(7'h23);
    n_chk++; if (gv.code_err !== 1'b0) $display("FAIL bad_recover_err got %0b want 0", gv.code_err); else n_pass++;
    n_chk++; if (st !== OK || err_cnt !== 8'd1) $display("FAIL bad_recover got st=%0d cnt=%0d want 0/1", st, err_cnt); else n_pass++;
  endtask

  task automatic test_fault();
    logic exp_f [3];
    exp_f = '{1'b0, 1'b0, 1'b1};
    gv.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(7'h00);
      n_chk++; if (fault !== exp_f[i]) $display("FAIL fault_step_%0d got %0b want %0b", i, fault, exp_f[i]); else n_pass++;
    end
    n_chk++; if (err_cnt !== 8'd4) $display("FAIL fault_err_cnt got %0d want 4", err_cnt); else n_pass++;
    send(7'h6C);
    n_chk++; if (fault !== 1'b1 || gv.code_err !== 1'b0) $display("FAIL fault_sticky got fault=%0b err=%0b want 1/0", fault, gv.code_err); else n_pass++;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_chk++; if (fault !== 1'b0 || st !== OK || err_cnt !== 8'd0) $display("FAIL fault_clear got fault=%0b st=%0d cnt=%0d want 0/0/0", fault, st, err_cnt); else n_pass++;
    // clear together with a bad accept: counter and state cleared, output still decoded
    send(7'h00);
    clear = 1'b1;
    send(7'h00);
    clear = 1'b0;
    n_chk++; if (err_cnt !== 8'd0 || st !== OK) $display("FAIL clear_vs_bad got cnt=%0d st=%0d want 0/0", err_cnt, st); else n_pass++;
    n_chk++; if (gv.code_err !== 1'b1) $display("FAIL clear_vs_bad_err got %0b want 1", gv.code_err); else n_pass++;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_c [5];
    exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    gvs.out_ready = 1'b1;
    gvs.z = 7'h00;
    for (int i = 0; i < 5; i++) begin
      gvs.in_valid = 1'b1;
      tick();
      n_chk++; if (err_cnt_s !== exp_c[i]) $display("FAIL sat_cnt_%0d got %0d want %0d", i, err_cnt_s, exp_c[i]); else n_pass++;
    end
    clear_s = 1'b1;
    tick();
    clear_s = 1'b0;
    gvs.in_valid = 1'b0;
    n_chk++; if (err_cnt_s !== 2'd0 || st_s !== OK) $display("FAIL sat_clear got cnt=%0d st=%0d want 0/0", err_cnt_s, st_s); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    gv.out_ready = 1'b0;
    send(7'h16);
    n_chk++; if (gv.out_valid !== 1'b1) $display("FAIL mid_pre got %0b want 1", gv.out_valid); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (gv.out_valid !== 1'b0 || gv.a !== 1'b0) $display("FAIL mid_reset got v=%0b a=%0b want 0/0", gv.out_valid, gv.a); else n_pass++;
    tick();
    rst_n = 1'b1;
    gv.out_ready = 1'b1;
    tick();
  endtask

`ifdef GVD_SYNDROME_EN
  task automatic test_syndrome();
    gv.out_ready = 1'b1;
    send(7'h6D);
    n_chk++; if (gv.syndrome !== 7'h01) $display("FAIL syndrome got %02h want 01", gv.syndrome); else n_pass++;
    send(7'h23);
    n_chk++; if (gv.syndrome !== 7'h00) $display("FAIL syndrome_legal got %02h want 00", gv.syndrome); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_legal_sweep();
    test_backpressure();
    test_bad_code();
    test_fault();
    test_saturation();
    test_reset_mid();
`ifdef GVD_SYNDROME_EN
    test_syndrome();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
